// File: rtl/uart_frame_tx.sv
// uart_frame_tx: framed serial transmitter.
// Frame: start bit (0), DATA_W payload bits LSB first, optional CKSUM_W-bit
// folded-XOR checksum LSB first, STOP_BITS stop bits (1). Every bit is held
// for CLKS_PER_BIT clk cycles. All outputs come straight from registers.
// Optional feature: define UART_FRAME_TX_CKSUM_EN to add the CKSUM state and
// the checksum field; without it DATA goes directly to STOP.
module uart_frame_tx #(
  parameter int DATA_W       = 12,
  parameter int CLKS_PER_BIT = 1088,
  parameter int CKSUM_W      = 8,
  parameter int STOP_BITS    = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic              tx,
  output logic              busy,
  output logic              frame_done
);

  // The bit counter covers the longer of the payload and checksum fields.
  localparam int MAX_W  = (DATA_W > CKSUM_W) ? DATA_W : CKSUM_W;
  localparam int BIT_W  = $clog2(MAX_W + 1);
  localparam int BAUD_W = $clog2(CLKS_PER_BIT);

  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [BAUD_W-1:0] BAUD_ONE  = BAUD_W'(1);
  localparam logic [BIT_W-1:0]  BIT_ONE   = BIT_W'(1);
  localparam logic [BIT_W-1:0]  DATA_LAST = BIT_W'(DATA_W - 1);
  localparam logic [BIT_W-1:0]  STOP_LAST = BIT_W'(STOP_BITS - 1);

`ifdef UART_FRAME_TX_CKSUM_EN
  // Fold index: which checksum bit the next payload bit is XORed into.
  localparam int FOLD_W = $clog2(CKSUM_W + 1);
  localparam logic [FOLD_W-1:0] FOLD_LAST  = FOLD_W'(CKSUM_W - 1);
  localparam logic [FOLD_W-1:0] FOLD_ONE   = FOLD_W'(1);
  localparam logic [BIT_W-1:0]  CKSUM_LAST = BIT_W'(CKSUM_W - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_CKSUM,
    S_STOP
  } state_e;
`else
  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
  } state_e;
`endif

  state_e              state_q, state_d;
  logic [BAUD_W-1:0]   baud_q, baud_d;
  logic [BIT_W-1:0]    bit_q, bit_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic                tx_q, tx_d;
  logic                ready_q, ready_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;

  logic                baud_end;
  logic [BIT_W-1:0]    bit_inc;
  logic [DATA_W-1:0]   data_sh;

`ifdef UART_FRAME_TX_CKSUM_EN
  logic [CKSUM_W-1:0]  cksum_q, cksum_d;
  logic [FOLD_W-1:0]   fold_q, fold_d;
  logic [FOLD_W-1:0]   fold_inc;
`endif

  // The baud counter counts down; reaching zero marks the last cycle of a bit.
  assign baud_end = (baud_q == '0);

  // Next-state and next-output logic for the frame sequencer.
  always_comb begin
    // NOTE: every _d signal takes its hold value first, so no path through the
    // case statement leaves a variable unassigned and no latch is inferred.
    state_d = state_q;
    baud_d  = baud_end ? BAUD_LAST : (baud_q - BAUD_ONE);
    bit_d   = bit_q;
    data_d  = data_q;
    tx_d    = tx_q;
    ready_d = ready_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    bit_inc = bit_q + BIT_ONE;
    // Payload bit that follows the one currently on the line.
    data_sh = data_q >> bit_inc;
`ifdef UART_FRAME_TX_CKSUM_EN
    cksum_d  = cksum_q;
    fold_d   = fold_q;
    fold_inc = (fold_q == FOLD_LAST) ? '0 : (fold_q + FOLD_ONE);
`endif

    unique case (state_q)
      S_IDLE: begin
        // Keep the baud counter primed so START lasts a full bit period.
        baud_d = BAUD_LAST;
        tx_d   = 1'b1;
        if (tx_valid && ready_q) begin
          data_d  = tx_data;
          bit_d   = '0;
          tx_d    = 1'b0;
          ready_d = 1'b0;
          busy_d  = 1'b1;
          state_d = S_START;
`ifdef UART_FRAME_TX_CKSUM_EN
          cksum_d = '0;
          fold_d  = '0;
`endif
        end
      end

      S_START: begin
        if (baud_end) begin
          // Payload bit 0 goes on the line; the checksum accumulates each
          // payload bit as it is launched so it is complete when DATA ends.
          tx_d    = data_q[0];
          bit_d   = '0;
          state_d = S_DATA;
`ifdef UART_FRAME_TX_CKSUM_EN
          cksum_d = cksum_q ^ (CKSUM_W'(data_q[0]) << fold_q);
          fold_d  = fold_inc;
`endif
        end
      end

      S_DATA: begin
        if (baud_end) begin
          if (bit_q == DATA_LAST) begin
            bit_d = '0;
`ifdef UART_FRAME_TX_CKSUM_EN
            tx_d    = cksum_q[0];
            cksum_d = cksum_q >> 1;
            state_d = S_CKSUM;
`else
            tx_d    = 1'b1;
            state_d = S_STOP;
`endif
          end else begin
            bit_d = bit_inc;
            tx_d  = data_sh[0];
`ifdef UART_FRAME_TX_CKSUM_EN
            cksum_d = cksum_q ^ (CKSUM_W'(data_sh[0]) << fold_q);
            fold_d  = fold_inc;
`endif
          end
        end
      end

`ifdef UART_FRAME_TX_CKSUM_EN
      S_CKSUM: begin
        if (baud_end) begin
          if (bit_q == CKSUM_LAST) begin
            bit_d   = '0;
            tx_d    = 1'b1;
            state_d = S_STOP;
          end else begin
            // Checksum is shifted out of the accumulator LSB first.
            bit_d   = bit_inc;
            tx_d    = cksum_q[0];
            cksum_d = cksum_q >> 1;
          end
        end
      end
`endif

      S_STOP: begin
        tx_d = 1'b1;
        // Registered pulse: raised one edge early so it is high exactly
        // during the final cycle of the last stop bit.
        if ((bit_q == STOP_LAST) && (baud_q == BAUD_ONE)) begin
          done_d = 1'b1;
        end
        if (baud_end) begin
          if (bit_q == STOP_LAST) begin
            bit_d   = '0;
            ready_d = 1'b1;
            busy_d  = 1'b0;
            state_d = S_IDLE;
          end else begin
            bit_d = bit_inc;
          end
        end
      end

      default: begin
        tx_d    = 1'b1;
        ready_d = 1'b1;
        busy_d  = 1'b0;
        bit_d   = '0;
        state_d = S_IDLE;
      end
    endcase
  end

  // State, counter, payload and output registers; reset parks the line high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      // NOTE: the payload register is a plain register, not a memory, so it
      // is cleared with the rest; a reset-free RAM would not be.
      data_q  <= '0;
      tx_q    <= 1'b1;
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef UART_FRAME_TX_CKSUM_EN
      cksum_q <= '0;
      fold_q  <= '0;
`endif
    end else begin
      // NOTE: non-blocking assignments make every register sample pre-edge
      // values, independent of statement order.
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      data_q  <= data_d;
      tx_q    <= tx_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
`ifdef UART_FRAME_TX_CKSUM_EN
      cksum_q <= cksum_d;
      fold_q  <= fold_d;
`endif
    end
  end

  assign tx         = tx_q;
  assign tx_ready   = ready_q;
  assign busy       = busy_q;
  assign frame_done = done_q;

endmodule

// File: tb/tb_uart_frame_tx.sv
// tb_uart_frame_tx: directed bench for uart_frame_tx.
// dut_a: DATA_W=12, CKSUM_W=8, CLKS_PER_BIT=4, STOP_BITS=1.
// dut_b: DATA_W=12, CKSUM_W=8, CLKS_PER_BIT=2, STOP_BITS=2.
// Expectations follow UART_FRAME_TX_CKSUM_EN as defined for the build.
module tb_uart_frame_tx;

  localparam int PERIOD = 10;
  localparam int CA     = 4;
  localparam int CB     = 2;
`ifdef UART_FRAME_TX_CKSUM_EN
  localparam int CKB    = 8;
`else
  localparam int CKB    = 0;
`endif
  localparam int NBITS_A = 1 + 12 + CKB + 1;
  localparam int NBITS_B = 1 + 12 + CKB + 2;
  localparam int FRAME_A = NBITS_A * CA;   // 88 with checksum, 56 without
  localparam int FRAME_B = NBITS_B * CB;   // 46 with checksum, 30 without

  logic        clk;
  logic        rst_n;
  logic [11:0] data_a, data_b;
  logic        valid_a, valid_b;
  logic        ready_a, ready_b;
  logic        tx_a, tx_b;
  logic        busy_a, busy_b;
  logic        done_a, done_b;

  int checks;
  int failures;

  uart_frame_tx #(.DATA_W(12), .CLKS_PER_BIT(CA), .CKSUM_W(8), .STOP_BITS(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .tx_data(data_a), .tx_valid(valid_a),
    .tx_ready(ready_a), .tx(tx_a), .busy(busy_a), .frame_done(done_a)
  );

  uart_frame_tx #(.DATA_W(12), .CLKS_PER_BIT(CB), .CKSUM_W(8), .STOP_BITS(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .tx_data(data_b), .tx_valid(valid_b),
    .tx_ready(ready_b), .tx(tx_b), .busy(busy_b), .frame_done(done_b)
  );

  initial clk = 1'b0;
  always #(PERIOD / 2) clk = ~clk;

  // Expected line level per bit slot: start, payload LSB first, hand-computed
  // checksum LSB first (when built in), then ones for the stop bits.
  function automatic logic [63:0] frame_bits(input logic [11:0] w, input logic [7:0] ck);
    logic [63:0] v;
    int n;
    v    = '1;
    v[0] = 1'b0;
    n    = 1;
    for (int i = 0; i < 12; i++) begin
      v[n] = w[i];
      n++;
    end
`ifdef UART_FRAME_TX_CKSUM_EN
    for (int i = 0; i < 8; i++) begin
      v[n] = ck[i];
      n++;
    end
`else
    if (ck === 8'hxx) v[63] = 1'b1;
`endif
    return v;
  endfunction

  // Watches one dut_a frame starting right after its handshake edge.
  // mode 0: drop tx_valid; mode 1: keep tx_valid, present next_w;
  // mode 2: scramble tx_data and toggle tx_valid every cycle while busy.
  task automatic monitor_a(input string name, input logic [11:0] w, input logic [7:0] ck,
                           input int mode, input logic [11:0] next_w,
                           output time t_done, output time t_start);
    logic [63:0] exp_v, obs_v;
    int glitches, done_cnt, done_at, busy_err;
    exp_v    = frame_bits(w, ck);
    obs_v    = '1;
    glitches = 0;
    done_cnt = 0;
    done_at  = -1;
    busy_err = 0;
    t_done   = 0;
    t_start  = 0;
    for (int k = 1; k <= FRAME_A; k++) begin
      @(negedge clk);
      if (tx_a !== exp_v[(k-1)/CA]) glitches++;
      if ((k - 1) % CA == CA / 2) obs_v[(k-1)/CA] = tx_a;
      if (k == 1 && tx_a === 1'b0) t_start = $time;
      if (done_a === 1'b1) begin
        done_cnt++;
        done_at = k;
        t_done  = $time;
      end
      if (ready_a !== 1'b0 || busy_a !== 1'b1) busy_err++;
      case (mode)
        1: if (k == 1) data_a = next_w;
        2: begin
          if (k < FRAME_A) begin
            data_a  = 12'($urandom);
            valid_a = k[0];
          end else begin
            valid_a = 1'b0;
          end
        end
        default: valid_a = 1'b0;
      endcase
    end
    checks++;
    if (obs_v !== exp_v) begin
      failures++;
      $display("FAIL %s bits: got %h want %h", name, obs_v[NBITS_A-1:0], exp_v[NBITS_A-1:0]);
    end
    checks++;
    if (glitches !== 0) begin
      failures++;
      $display("FAIL %s bit hold: got %0d off-level cycles want 0", name, glitches);
    end
    checks++;
    if (done_cnt !== 1 || done_at !== FRAME_A) begin
      failures++;
      $display("FAIL %s frame_done: got %0d pulses last at cycle %0d want 1 at cycle %0d",
               name, done_cnt, done_at, FRAME_A);
    end
    checks++;
    if (busy_err !== 0) begin
      failures++;
      $display("FAIL %s ready/busy in frame: got %0d bad cycles want 0", name, busy_err);
    end
    @(negedge clk);
    checks++;
    if (ready_a !== 1'b1 || busy_a !== 1'b0 || tx_a !== 1'b1 || done_a !== 1'b0) begin
      failures++;
      $display("FAIL %s idle after frame: got ready=%b busy=%b tx=%b done=%b want 1 0 1 0",
               name, ready_a, busy_a, tx_a, done_a);
    end
  endtask

  task automatic test_reset();
    rst_n   = 1'b0;
    valid_a = 1'b0;
    valid_b = 1'b0;
    data_a  = '0;
    data_b  = '0;
    repeat (3) @(negedge clk);
    checks++;
    if (tx_a !== 1'b1 || busy_a !== 1'b0 || done_a !== 1'b0) begin
      failures++;
      $display("FAIL reset a: got tx=%b busy=%b done=%b want 1 0 0", tx_a, busy_a, done_a);
    end
    checks++;
    if (tx_b !== 1'b1 || busy_b !== 1'b0 || done_b !== 1'b0) begin
      failures++;
      $display("FAIL reset b: got tx=%b busy=%b done=%b want 1 0 0", tx_b, busy_b, done_b);
    end
    rst_n = 1'b1;
    #1;
    checks++;
    if (ready_a !== 1'b1 || ready_b !== 1'b1) begin
      failures++;
      $display("FAIL ready after release: got a=%b b=%b want 1 1", ready_a, ready_b);
    end
  endtask

  task automatic test_idle();
    int bad;
    bad = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (tx_a !== 1'b1 || ready_a !== 1'b1 || busy_a !== 1'b0 || done_a !== 1'b0) bad++;
    end
    checks++;
    if (bad !== 0) begin
      failures++;
      $display("FAIL idle hold: got %0d bad cycles want 0", bad);
    end
  endtask

  task automatic test_single();
    time td, ts;
    @(negedge clk);
    data_a  = 12'h416;
    valid_a = 1'b1;
    @(posedge clk);
    monitor_a("single_416", 12'h416, 8'h12, 0, 12'h000, td, ts);
  endtask

  task automatic test_back_to_back();
    time td1, ts1, td2, ts2;
    @(negedge clk);
    data_a  = 12'hFFF;
    valid_a = 1'b1;
    @(posedge clk);
    monitor_a("b2b_fff", 12'hFFF, 8'hF0, 1, 12'h000, td1, ts1);
    @(posedge clk);
    monitor_a("b2b_000", 12'h000, 8'h00, 0, 12'h000, td2, ts2);
    // frame_done cycle, one ready cycle, then the start bit.
    checks++;
    if (ts2 - td1 !== 2 * PERIOD) begin
      failures++;
      $display("FAIL b2b start after done: got %0d cycles want 2",
               int'((ts2 - td1) / PERIOD));
    end
  endtask

  task automatic test_midframe_reset();
    int dcnt;
    time td, ts;
    dcnt = 0;
    @(negedge clk);
    data_a  = 12'h416;
    valid_a = 1'b1;
    @(posedge clk);
    // Cycles 25..28 carry payload bit 5 (0 for 0x416).
    for (int k = 1; k <= 26; k++) begin
      @(negedge clk);
      valid_a = 1'b0;
      if (done_a === 1'b1) dcnt++;
    end
    checks++;
    if (tx_a !== 1'b0 || busy_a !== 1'b1) begin
      failures++;
      $display("FAIL pre-reset data bit 5: got tx=%b busy=%b want 0 1", tx_a, busy_a);
    end
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if (tx_a !== 1'b1 || busy_a !== 1'b0 || done_a !== 1'b0) begin
      failures++;
      $display("FAIL async reset: got tx=%b busy=%b done=%b want 1 0 0", tx_a, busy_a, done_a);
    end
    repeat (3) begin
      @(negedge clk);
      if (done_a === 1'b1) dcnt++;
    end
    data_a  = 12'h001;
    valid_a = 1'b1;
    rst_n   = 1'b1;
    #1;
    checks++;
    if (ready_a !== 1'b1) begin
      failures++;
      $display("FAIL ready after mid-frame reset: got %b want 1", ready_a);
    end
    checks++;
    if (dcnt !== 0) begin
      failures++;
      $display("FAIL aborted frame_done: got %0d pulses want 0", dcnt);
    end
    @(posedge clk);
    monitor_a("post_reset_001", 12'h001, 8'h01, 0, 12'h000, td, ts);
  endtask

  task automatic test_stability();
    time td, ts;
    @(negedge clk);
    data_a  = 12'h5A3;
    valid_a = 1'b1;
    @(posedge clk);
    monitor_a("stable_5a3", 12'h5A3, 8'hA6, 2, 12'h000, td, ts);
  endtask

  task automatic test_stop2();
    logic [63:0] exp_v, obs_v;
    int glitches, done_at, run, stop_run;
    exp_v    = frame_bits(12'h416, 8'h12);
    obs_v    = '1;
    glitches = 0;
    done_at  = -1;
    run      = 0;
    stop_run = -1;
    @(negedge clk);
    data_b  = 12'h416;
    valid_b = 1'b1;
    @(posedge clk);
    for (int k = 1; k <= FRAME_B; k++) begin
      @(negedge clk);
      valid_b = 1'b0;
      if (tx_b !== exp_v[(k-1)/CB]) glitches++;
      if ((k - 1) % CB == 1) obs_v[(k-1)/CB] = tx_b;
      run = (tx_b === 1'b1) ? run + 1 : 0;
      if (done_b === 1'b1) begin
        done_at  = k;
        stop_run = run;
      end
    end
    checks++;
    if (obs_v !== exp_v || glitches !== 0) begin
      failures++;
      $display("FAIL stop2 bits: got %h (%0d off-level cycles) want %h",
               obs_v[NBITS_B-1:0], glitches, exp_v[NBITS_B-1:0]);
    end
    checks++;
    if (done_at !== FRAME_B) begin
      failures++;
      $display("FAIL stop2 frame length: got %0d want %0d", done_at, FRAME_B);
    end
    checks++;
    if (stop_run !== 4) begin
      failures++;
      $display("FAIL stop2 stop level: got %0d cycles want 4", stop_run);
    end
    @(negedge clk);
    checks++;
    if (ready_b !== 1'b1 || busy_b !== 1'b0 || tx_b !== 1'b1) begin
      failures++;
      $display("FAIL stop2 idle after: got ready=%b busy=%b tx=%b want 1 0 1",
               ready_b, busy_b, tx_b);
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    test_idle();
    test_single();
    test_back_to_back();
    test_midframe_reset();
    test_stability();
    test_stop2();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
